// File: rtl/fsm_pkg.sv
// Shared types and timing constants for the calibration sequencer.
package fsm_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARMED      = 3'd1,
        DELAY      = 3'd2,
        WAIT_PHASE = 3'd3,
        TRIGGER    = 3'd4,
        DONE       = 3'd5
    } scenario_state_t;

    localparam int unsigned CLOCK_HZ              = 200_000_000;
    // 9 ms and 100 ns at CLOCK_HZ.
    localparam int unsigned DEFAULT_DELAY_CYCLES  = 1_800_000;
    localparam int unsigned DEFAULT_TRIGGER_WIDTH = 20;
    localparam int unsigned DEFAULT_SYNC_STAGES   = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer followed by a rising-edge detector.
// The edge pulse is one cycle wide and is decoded from the registered previous level.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_signal,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   prev;

    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            sync_chain <= '0;
            prev       <= 1'b0;
        end else begin
            sync_chain[0] <= async_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_chain[i] <= sync_chain[i-1];
            end
            prev <= sync_chain[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_chain[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev;

endmodule

// File: rtl/fsm_calibration.sv
// Calibration sequencer: start -> fast-gate pulse -> programmable delay -> phase
// alignment -> one fixed-width trigger, with a running trigger count.
module fsm_calibration
    import fsm_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES  = DEFAULT_DELAY_CYCLES,
    parameter int unsigned TRIGGER_WIDTH = DEFAULT_TRIGGER_WIDTH,
    parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic        clock,
    input  logic        reset_signal,
    input  logic        start_signal,
    input  logic        fg_signal,
    input  logic        phase_signal,
    output logic        output_trigger,
    output logic [2:0]  scenario_state,
    output logic [31:0] counter_out
);

    localparam int unsigned DW = $clog2(DELAY_CYCLES + 1);
    localparam int unsigned WW = $clog2(TRIGGER_WIDTH + 1);
    localparam logic [DW-1:0] DELAY_LAST = DW'(DELAY_CYCLES - 1);
    localparam logic [WW-1:0] WIDTH_LAST = WW'(TRIGGER_WIDTH - 1);

    logic [2:0] levels_unused;
    logic       start_rise;
    logic       fg_rise;
    logic       phase_rise;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .clock        (clock),
        .reset_signal (reset_signal),
        .async_in     (start_signal),
        .sync_out     (levels_unused[0]),
        .rise         (start_rise)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_fg_sync (
        .clock        (clock),
        .reset_signal (reset_signal),
        .async_in     (fg_signal),
        .sync_out     (levels_unused[1]),
        .rise         (fg_rise)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_phase_sync (
        .clock        (clock),
        .reset_signal (reset_signal),
        .async_in     (phase_signal),
        .sync_out     (levels_unused[2]),
        .rise         (phase_rise)
    );

    scenario_state_t state_q;
    scenario_state_t state_next;
    logic [DW-1:0]   delay_cnt;
    logic [WW-1:0]   width_cnt;
    logic [31:0]     event_count;
    logic            trigger_q;
    logic            arm_delay;
    logic            fire;

    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        arm_delay  = 1'b0;
        fire       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_rise) state_next = ARMED;
            end
            ARMED: begin
                if (fg_rise) begin
                    state_next = DELAY;
                    arm_delay  = 1'b1;
                end
            end
            DELAY: begin
                if (delay_cnt == DELAY_LAST) state_next = WAIT_PHASE;
            end
            WAIT_PHASE: begin
                if (phase_rise) begin
                    state_next = TRIGGER;
                    fire       = 1'b1;
                end
            end
            TRIGGER: begin
                if (width_cnt == WIDTH_LAST) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Delay, pulse-width and event counters; the trigger flop follows the next state
    // so it rises and falls on exactly the edges that enter and leave TRIGGER.
    always_ff @(posedge clock or posedge reset_signal) begin
        if (reset_signal) begin
            delay_cnt   <= '0;
            width_cnt   <= '0;
            event_count <= '0;
            trigger_q   <= 1'b0;
        end else begin
            if (arm_delay) begin
                delay_cnt <= '0;
            end else if (state_q == DELAY) begin
                delay_cnt <= delay_cnt + DW'(1);
            end

            if (state_q == TRIGGER) begin
                width_cnt <= width_cnt + WW'(1);
            end else begin
                width_cnt <= '0;
            end

            if (fire) begin
                event_count <= event_count + 32'd1;
            end

            trigger_q <= (state_next == TRIGGER);
        end
    end

    assign output_trigger = trigger_q;
    assign scenario_state = state_q;
    assign counter_out    = event_count;

endmodule

// File: tb/tb_fsm_calibration.sv
// Directed bench for fsm_calibration with DELAY_CYCLES=1000, TRIGGER_WIDTH=20.
module tb_fsm_calibration;

    logic        clock;
    logic        reset_signal;
    logic        start_signal;
    logic        fg_signal;
    logic        phase_signal;
    logic        output_trigger;
    logic [2:0]  scenario_state;
    logic [31:0] counter_out;

    int compared   = 0;
    int mismatched = 0;

    fsm_calibration #(
        .DELAY_CYCLES  (1000),
        .TRIGGER_WIDTH (20),
        .SYNC_STAGES   (2)
    ) dut (
        .clock          (clock),
        .reset_signal   (reset_signal),
        .start_signal   (start_signal),
        .fg_signal      (fg_signal),
        .phase_signal   (phase_signal),
        .output_trigger (output_trigger),
        .scenario_state (scenario_state),
        .counter_out    (counter_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_signal = 1'b1;
        tick(2);
        reset_signal = 1'b0;
        tick(2);
    endtask

    // Full shot from IDLE; returns cycles from the fg pin edge to trigger rise.
    task automatic shot_until_trigger(output bit ok, output int lat);
        int n;
        start_signal = 1'b1; tick(4); start_signal = 1'b0; tick(2);
        fg_signal = 1'b1; n = 0;
        tick(4); n += 4; fg_signal = 1'b0;
        while (scenario_state != 3'd3 && n < 1500) begin tick(1); n++; end
        phase_signal = 1'b1;
        while (output_trigger != 1'b1 && n < 1520) begin tick(1); n++; end
        phase_signal = 1'b0;
        lat = n;
        ok  = output_trigger;
    endtask

    task automatic test_reset();
        reset_signal = 1'b1; start_signal = 1'b0; fg_signal = 1'b0; phase_signal = 1'b0;
        tick(3);
        compared++; if (output_trigger !== 1'b0) begin mismatched++; $display("FAIL reset_trigger: got %b want 0", output_trigger); end
        compared++; if (scenario_state !== 3'd0) begin mismatched++; $display("FAIL reset_state: got %0d want 0", scenario_state); end
        compared++; if (counter_out !== 32'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", counter_out); end
        reset_signal = 1'b0;
        tick(2);
    endtask

    task automatic test_nominal();
        int w;
        start_signal = 1'b1; tick(4); start_signal = 1'b0;
        compared++; if (scenario_state !== 3'd1) begin mismatched++; $display("FAIL nominal_armed: got %0d want 1", scenario_state); end
        tick(4);
        fg_signal = 1'b1; tick(3);
        compared++; if (scenario_state !== 3'd2) begin mismatched++; $display("FAIL nominal_delay_entry: got %0d want 2", scenario_state); end
        tick(10); fg_signal = 1'b0;
        tick(400); phase_signal = 1'b1; tick(60); phase_signal = 1'b0;
        tick(529);
        compared++; if (scenario_state !== 3'd2) begin mismatched++; $display("FAIL nominal_delay_last: got %0d want 2", scenario_state); end
        tick(1);
        compared++; if (scenario_state !== 3'd3) begin mismatched++; $display("FAIL nominal_wait_phase: got %0d want 3", scenario_state); end
        tick(5);
        phase_signal = 1'b1; tick(2);
        compared++; if (output_trigger !== 1'b0) begin mismatched++; $display("FAIL nominal_trig_early: got %b want 0", output_trigger); end
        tick(1); phase_signal = 1'b0;
        compared++; if (output_trigger !== 1'b1) begin mismatched++; $display("FAIL nominal_trig_rise: got %b want 1", output_trigger); end
        compared++; if (scenario_state !== 3'd4) begin mismatched++; $display("FAIL nominal_trigger_state: got %0d want 4", scenario_state); end
        compared++; if (counter_out !== 32'd1) begin mismatched++; $display("FAIL nominal_count: got %0d want 1", counter_out); end
        w = 0;
        while (output_trigger === 1'b1 && w < 100) begin tick(1); w++; end
        compared++; if (w !== 20) begin mismatched++; $display("FAIL nominal_width: got %0d want 20", w); end
        compared++; if (scenario_state !== 3'd5) begin mismatched++; $display("FAIL nominal_done: got %0d want 5", scenario_state); end
        tick(1);
        compared++; if (scenario_state !== 3'd0) begin mismatched++; $display("FAIL nominal_idle: got %0d want 0", scenario_state); end
        tick(10);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        for (int k = 0; k < 2; k++) begin
            shot_until_trigger(ok, lat);
            compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL b2b_trigger%0d: got %b want 1", k, ok); end
            compared++; if (lat !== 1006) begin mismatched++; $display("FAIL b2b_latency%0d: got %0d want 1006", k, lat); end
            tick(40);
        end
        compared++; if (counter_out !== 32'd3) begin mismatched++; $display("FAIL b2b_count: got %0d want 3", counter_out); end
    endtask

    task automatic test_ignored_events();
        int n;
        start_signal = 1'b1; tick(4); start_signal = 1'b0; tick(4);
        fg_signal = 1'b1; tick(4); fg_signal = 1'b0;
        tick(100); start_signal = 1'b1; tick(4); start_signal = 1'b0;
        tick(100); fg_signal = 1'b1; tick(4); fg_signal = 1'b0;
        tick(790);
        compared++; if (scenario_state !== 3'd2) begin mismatched++; $display("FAIL ignore_delay_kept: got %0d want 2", scenario_state); end
        tick(1);
        compared++; if (scenario_state !== 3'd3) begin mismatched++; $display("FAIL ignore_wait_phase: got %0d want 3", scenario_state); end
        phase_signal = 1'b1; tick(3); phase_signal = 1'b0;
        compared++; if (output_trigger !== 1'b1) begin mismatched++; $display("FAIL ignore_trig_rise: got %b want 1", output_trigger); end
        tick(5); start_signal = 1'b1; tick(4); start_signal = 1'b0;
        n = 0;
        while (scenario_state != 3'd0 && n < 100) begin tick(1); n++; end
        tick(40);
        compared++; if (scenario_state !== 3'd0) begin mismatched++; $display("FAIL ignore_no_queue: got %0d want 0", scenario_state); end
        compared++; if (counter_out !== 32'd4) begin mismatched++; $display("FAIL ignore_count: got %0d want 4", counter_out); end
    endtask

    task automatic test_start_held();
        int n;
        start_signal = 1'b1; tick(4);
        compared++; if (scenario_state !== 3'd1) begin mismatched++; $display("FAIL held_armed: got %0d want 1", scenario_state); end
        fg_signal = 1'b1; tick(4); fg_signal = 1'b0;
        n = 0;
        while (scenario_state != 3'd3 && n < 1500) begin tick(1); n++; end
        phase_signal = 1'b1; tick(4); phase_signal = 1'b0;
        n = 0;
        while (scenario_state != 3'd0 && n < 100) begin tick(1); n++; end
        tick(50);
        compared++; if (scenario_state !== 3'd0) begin mismatched++; $display("FAIL held_stay_idle: got %0d want 0", scenario_state); end
        compared++; if (counter_out !== 32'd5) begin mismatched++; $display("FAIL held_count: got %0d want 5", counter_out); end
        start_signal = 1'b0; tick(4); start_signal = 1'b1; tick(4);
        compared++; if (scenario_state !== 3'd1) begin mismatched++; $display("FAIL held_rearm: got %0d want 1", scenario_state); end
        start_signal = 1'b0;
        do_reset();
    endtask

    task automatic test_same_cycle();
        start_signal = 1'b1; fg_signal = 1'b1; tick(4);
        compared++; if (scenario_state !== 3'd1) begin mismatched++; $display("FAIL same_armed: got %0d want 1", scenario_state); end
        start_signal = 1'b0; fg_signal = 1'b0; tick(20);
        compared++; if (scenario_state !== 3'd1) begin mismatched++; $display("FAIL same_fg_unused: got %0d want 1", scenario_state); end
        fg_signal = 1'b1; tick(4); fg_signal = 1'b0;
        compared++; if (scenario_state !== 3'd2) begin mismatched++; $display("FAIL same_next_fg: got %0d want 2", scenario_state); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int lat;
        start_signal = 1'b1; tick(4); start_signal = 1'b0; tick(2);
        fg_signal = 1'b1; tick(4); fg_signal = 1'b0; tick(100);
        #2 reset_signal = 1'b1; #1;
        compared++; if (scenario_state !== 3'd0) begin mismatched++; $display("FAIL rstmid_delay_state: got %0d want 0", scenario_state); end
        tick(2); reset_signal = 1'b0; tick(2);
        shot_until_trigger(ok, lat);
        compared++; if (counter_out !== 32'd1) begin mismatched++; $display("FAIL rstmid_pre_count: got %0d want 1", counter_out); end
        tick(5);
        #2 reset_signal = 1'b1; #1;
        compared++; if (output_trigger !== 1'b0) begin mismatched++; $display("FAIL rstmid_trigger: got %b want 0", output_trigger); end
        compared++; if (scenario_state !== 3'd0) begin mismatched++; $display("FAIL rstmid_state: got %0d want 0", scenario_state); end
        compared++; if (counter_out !== 32'd0) begin mismatched++; $display("FAIL rstmid_count: got %0d want 0", counter_out); end
        repeat (20) @(posedge clock);
        #1 reset_signal = 1'b0;
        tick(2);
        fg_signal = 1'b1; tick(4); fg_signal = 1'b0; tick(10);
        compared++; if (scenario_state !== 3'd0) begin mismatched++; $display("FAIL rstmid_no_rearm: got %0d want 0", scenario_state); end
        start_signal = 1'b1; tick(4); start_signal = 1'b0;
        compared++; if (scenario_state !== 3'd1) begin mismatched++; $display("FAIL rstmid_fresh_start: got %0d want 1", scenario_state); end
        do_reset();
    endtask

    task automatic test_counter_wrap();
        bit ok;
        int lat;
        force dut.event_count = 32'hFFFF_FFFF;
        tick(1);
        release dut.event_count;
        tick(1);
        compared++; if (counter_out !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL wrap_preload: got %h want ffffffff", counter_out); end
        shot_until_trigger(ok, lat);
        compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL wrap_trigger: got %b want 1", ok); end
        compared++; if (counter_out !== 32'd0) begin mismatched++; $display("FAIL wrap_count: got %h want 00000000", counter_out); end
        tick(40);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_ignored_events();
        test_start_held();
        test_same_cycle();
        test_reset_mid();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fsm_calibration.md
Name: fsm_calibration

Overview:
Calibration sequencer for the synchronization block.
- A start request arms the FSM.
- The FSM waits for the next fast-gate optical pulse and then for a programmable delay.
- It then aligns to the next rising edge of the accelerator phase signal and emits one fixed-width output trigger toward the detector.
- It exposes its current state and a running trigger count for monitoring.

Parameters:
- DELAY_CYCLES, 1_800_000: clock cycles from the fg_signal rising edge to the start of phase alignment (9 ms at 200 MHz).
- TRIGGER_WIDTH, 20: output_trigger high time in clock cycles (100 ns).
- SYNC_STAGES, 2: synchronizer flops on each asynchronous input.

Ports:
- clock, input, 1: system clock, 200 MHz nominal.
- reset_signal, input, 1: asynchronous, active-high reset.
- start_signal, input, 1: calibration request; its rising edge arms the FSM. Asynchronous to clock.
- fg_signal, input, 1: fast-gate opto pulse, 20 ms period, 100 us high. Asynchronous.
- phase_signal, input, 1: accelerator phase reference, about 1.2 us period. Asynchronous.
- output_trigger, output, 1: trigger pulse to the detector, registered.
- scenario_state, output, 3: current FSM state code.
- counter_out, output, 32: number of triggers issued since reset, unsigned.

Behaviour:
- Single clock domain. Every flop resets asynchronously when reset_signal = 1.
- Reset values: output_trigger = 0, scenario_state = IDLE (0), counter_out = 0, all synchronizers = 0, delay counter = 0.
- Input conditioning:
  - start_signal, fg_signal and phase_signal each pass through SYNC_STAGES flops, then a registered rising-edge detector (sync & ~prev).
  - An edge event therefore lasts 1 cycle and arrives SYNC_STAGES+1 cycles after the pin edge.
- States (scenario_state encoding):
  - IDLE = 0: waits for a start edge. On the start edge, go to ARMED.
  - ARMED = 1: waits for an fg edge. On the fg edge, clear the delay counter and go to DELAY.
  - DELAY = 2: the delay counter increments each cycle. When it reaches DELAY_CYCLES-1, go to WAIT_PHASE.
  - WAIT_PHASE = 3: waits for a phase edge. On the phase edge, go to TRIGGER. output_trigger rises on the same clock edge as the state change.
  - TRIGGER = 4: output_trigger = 1 for exactly TRIGGER_WIDTH cycles, then 0. Go to DONE.
  - DONE = 5: stays for 1 cycle, then returns to IDLE.
  - Codes 6 and 7 are illegal and recover to IDLE on the next clock.
- Trigger pulse: output_trigger is registered and glitch-free. At most one pulse per start edge.
- counter_out: increments by 1 on the cycle output_trigger rises. It wraps from 0xFFFFFFFF to 0. Only reset clears it.
- Ignored and boundary events:
  - Start edges outside IDLE are ignored and are not queued. A start held high does not re-arm; a new rising edge is required.
  - fg edges outside ARMED are ignored, including the falling edge and any fg edge during DELAY.
  - Phase edges before WAIT_PHASE are ignored.
  - If start and fg edges occur in the same cycle while in IDLE, go only to ARMED; that fg edge is not consumed.
- Reset mid-operation: immediate return to IDLE with output_trigger = 0 and the count cleared, including mid-pulse.
- Pin-to-output latency: the trigger rises SYNC_STAGES+1 cycles after the first phase_signal pin rising edge that occurs once DELAY has ended (WAIT_PHASE entered).

Decomposition:
- Shared package fsm_pkg:
  - scenario_state_t enum, 3 bits: IDLE=0, ARMED=1, DELAY=2, WAIT_PHASE=3, TRIGGER=4, DONE=5.
  - Timing constants CLOCK_HZ = 200_000_000, DEFAULT_DELAY_CYCLES, DEFAULT_TRIGGER_WIDTH.
- One sub-module, sync_edge_detect (parameter SYNC_STAGES; ports clock, reset_signal, async_in, sync_out, rise), instantiated three times.
- The FSM, delay counter, pulse-width counter and event counter stay in the top module.

Test Plan:
- Reset: assert reset_signal for 100 ns mid-operation and mid-pulse -> output_trigger = 0, scenario_state = 0 and counter_out = 0 asynchronously; the FSM re-arms only on a fresh start edge.
- Nominal shot (DELAY_CYCLES = 1000, TRIGGER_WIDTH = 20): start edge, then fg edge, then phase edges every 600 ns -> states step 0,1,2,3,4,5,0. The trigger rises 3 cycles after the first phase rising pin edge following 1000 DELAY cycles, stays high for exactly 20 cycles, and counter_out goes to 1.
- Two start pulses 20 ms apart with fg every 20 ms -> exactly 2 triggers, counter_out = 2, each trigger at least DELAY_CYCLES cycles after an fg edge.
- Start edge while in DELAY or TRIGGER, and extra fg edges in DELAY -> no extra trigger, counter unchanged, delay not restarted.
- Start held high across DONE -> FSM stays in IDLE with no second trigger until start falls and rises again.
- Counter wrap (force the count to 0xFFFFFFFF before a shot) -> counter_out = 0 after the trigger.
